// File: rtl/ahb2apb_multi_bridge_if.sv
// rtl/ahb2apb_multi_bridge_if.sv - AHB-Lite slave side and APB4 master side signal bundle
// The bridge takes the slave modport; the surrounding fabric/bench takes the master modport.
interface ahb2apb_multi_bridge_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PDATA_SIZE = 32,
  parameter int PADDR_SIZE = 16,
  parameter int NUM_SLAVES = 4
);
  logic                    HSEL;
  logic [HADDR_SIZE-1:0]   HADDR;
  logic [1:0]              HTRANS;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [HDATA_SIZE-1:0]   HWDATA;
  logic                    HREADY;
  logic                    HREADYOUT;
  logic                    HRESP;
  logic [HDATA_SIZE-1:0]   HRDATA;
  logic [NUM_SLAVES-1:0]   PSEL;
  logic                    PENABLE;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic                    PWRITE;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, PRDATA, PREADY, PSLVERR,
    output HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, PRDATA, PREADY, PSLVERR,
    input  HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB
  );
endinterface

// File: rtl/ahb2apb_multi_bridge.sv
// rtl/ahb2apb_multi_bridge.sv - AHB-Lite to APB4 bridge fanning one segment out to NUM_SLAVES PSEL lines
// Optional macro APB_TIMEOUT_EN: abort an ACCESS after TIMEOUT_CYCLES PREADY-low cycles with an AHB ERROR.
module ahb2apb_multi_bridge #(
  parameter int HADDR_SIZE     = 32,
  parameter int HDATA_SIZE     = 32,
  parameter int PDATA_SIZE     = 32,
  parameter int PADDR_SIZE     = 16,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_SEL_LSB    = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                   HCLK,
  input logic                   HRESETn,
  ahb2apb_multi_bridge_if.slave bus
);
  localparam int STRB_W = PDATA_SIZE / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2} state_e;

  state_e                state_q;
  logic                  hreadyout_q, hresp_q, penable_q, pwrite_q;
  logic [HDATA_SIZE-1:0] hrdata_q;
  logic [NUM_SLAVES-1:0] psel_q;
  logic [PADDR_SIZE-1:0] paddr_q;
  logic [PDATA_SIZE-1:0] pwdata_q;
  logic [STRB_W-1:0]     pstrb_q;
  logic [IDX_W-1:0]      idx_q;
  logic [LANE_W-1:0]     lane_q;
  logic [2:0]            size_q;

  logic [IDX_W-1:0]      idx_d;
  logic [LANE_W-1:0]     lane_d;
  logic                  accept_d, bad_d;
  logic                  unused_bits;

  function automatic logic aligned_f(input logic [2:0] size, input logic [LANE_W-1:0] lane);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < LANE_W; i++)
      if (i < int'(size) && lane[i]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [STRB_W-1:0] strb_f(input logic [2:0] size, input logic [LANE_W-1:0] lane);
    logic [STRB_W-1:0] m;
    m = '0;
    for (int i = 0; i < STRB_W; i++)
      if (i < (1 << size)) m[i] = 1'b1;
    return m << lane;
  endfunction

  assign idx_d    = bus.HADDR[SLV_SEL_LSB +: IDX_W];
  assign lane_d   = bus.HADDR[LANE_W-1:0];
  assign accept_d = bus.HSEL & bus.HREADY & bus.HTRANS[1] &
                    ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR2));
  // Decode misses and illegal sizes are rejected before any PSEL is driven.
  assign bad_d    = (int'(idx_d) >= NUM_SLAVES) || (int'(bus.HSIZE) > LANE_W) ||
                    !aligned_f(bus.HSIZE, lane_d);
  assign unused_bits = ^{bus.HTRANS[0], bus.HADDR};

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      size_q      <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE, ERR2: begin
          if (accept_d) begin
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            size_q      <= bus.HSIZE;
            hreadyout_q <= 1'b0;
            if (bad_d) begin
              hresp_q <= 1'b1;
              state_q <= ERR1;
            end else begin
              hresp_q  <= 1'b0;
              paddr_q  <= bus.HADDR[PADDR_SIZE-1:0];
              pwrite_q <= bus.HWRITE;
              if (bus.HWRITE) begin
                state_q <= WDATA;
              end else begin
                psel_q  <= NUM_SLAVES'(1) << idx_d;
                pstrb_q <= '0;
                state_q <= SETUP;
              end
            end
          end else begin
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            state_q     <= IDLE;
          end
        end
        WDATA: begin
          pwdata_q <= bus.HWDATA;
          pstrb_q  <= strb_f(size_q, lane_q);
          psel_q   <= NUM_SLAVES'(1) << idx_q;
          state_q  <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_q     <= '0;
`endif
        end
        ACCESS: begin
          if (bus.PREADY) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (bus.PSLVERR) begin
              hresp_q <= 1'b1;
              state_q <= ERR1;
            end else begin
              hreadyout_q <= 1'b1;
              state_q     <= DONE;
              if (!pwrite_q) hrdata_q <= bus.PRDATA;
            end
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            hresp_q   <= 1'b1;
            state_q   <= ERR1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        ERR1: begin
          hreadyout_q <= 1'b1;
          state_q     <= ERR2;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
endmodule

// File: tb/tb_ahb2apb_multi_bridge.sv
// tb/tb_ahb2apb_multi_bridge.sv - randomized self-checking bench for ahb2apb_multi_bridge
// APB responder model plus a transfer-level reference model; three slaves so index 3 is a decode miss.
module tb_ahb2apb_multi_bridge;
  localparam int NS  = 3;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb2apb_multi_bridge_if #(.NUM_SLAVES(NS)) bus ();
  ahb2apb_multi_bridge #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TMO)) dut (.HCLK(clk), .HRESETn(rst_n), .bus(bus));
  assign bus.HREADY = bus.HREADYOUT;

  int checks = 0;
  int errors = 0;

  int          cfg_waits = 0;
  bit          cfg_err = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  logic [31:0] model_rdata = 32'h0;

  int          wcnt = 0, apb_cnt = 0, stab_err = 0;
  logic [NS-1:0] s_sel, l_sel;
  logic [15:0]   s_addr, l_addr;
  logic          s_write, l_write;
  logic [31:0]   s_wdata, l_wdata;
  logic [3:0]    s_strb, l_strb;

  // APB slave: snapshots SETUP, checks ACCESS stability, completes after cfg_waits wait states.
  always @(negedge clk) begin
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = $urandom;
    if (!rst_n) begin
      wcnt = 0;
    end else if (bus.PSEL != '0 && !bus.PENABLE) begin
      s_sel = bus.PSEL; s_addr = bus.PADDR; s_write = bus.PWRITE; s_wdata = bus.PWDATA; s_strb = bus.PSTRB;
      wcnt = 0;
      if ($countones(bus.PSEL) != 1) stab_err++;
    end else if (bus.PSEL != '0) begin
      if ({bus.PSEL, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB} !== {s_sel, s_addr, s_write, s_wdata, s_strb})
        stab_err++;
      if (wcnt == cfg_waits) begin
        bus.PREADY = 1'b1; bus.PSLVERR = cfg_err; bus.PRDATA = cfg_rdata;
        l_sel = s_sel; l_addr = s_addr; l_write = s_write; l_wdata = s_wdata; l_strb = s_strb;
        apb_cnt++;
      end
      wcnt++;
    end else if (bus.PENABLE) begin
      stab_err++;
    end
  end

  function automatic void model(input logic [31:0] a, input bit w, input logic [2:0] sz, input int waits,
                                input bit slverr, output bit err, output int lat, output int napb,
                                output logic [NS-1:0] sel, output logic [3:0] strb);
    int idx, nb;
    bit dec_err;
    idx = int'(a[17:16]);
    nb  = 1 << sz;
    dec_err = (idx >= NS) || (sz > 3'd2) || ((a % nb) != 0);
    sel  = dec_err ? '0 : NS'(1 << idx);
    strb = (dec_err || !w) ? 4'h0 : 4'(((1 << nb) - 1) << (a % 4));
    if (dec_err) begin
      err = 1'b1; lat = 2; napb = 0;
    end else begin
      err = slverr; lat = (w ? 4 : 3) + waits + (slverr ? 1 : 0); napb = 1;
`ifdef APB_TIMEOUT_EN
      if (waits >= TMO) begin err = 1'b1; lat = (w ? 2 : 1) + TMO + 2; napb = 0; end
`endif
    end
  endfunction

  task automatic do_xfer(input logic [31:0] a, input bit w, input logic [2:0] sz, input logic [31:0] wd,
                         output int lat, output bit resp, output bit rprev, output logic [31:0] rd);
    bit rdy;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = a; bus.HWRITE = w; bus.HSIZE = sz;
    @(posedge clk); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = wd;
    lat = 0; resp = 1'b0; rprev = 1'b0; rdy = 1'b0;
    while (!rdy && lat < 200) begin
      @(negedge clk);
      lat++; rprev = resp; resp = bus.HRESP; rdy = bus.HREADYOUT;
    end
    rd = bus.HRDATA;
  endtask

  task automatic test_reset();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = '0; bus.HWRITE = 1'b0; bus.HSIZE = 3'd0; bus.HWDATA = '0;
    repeat (2) @(negedge clk);
    checks++; if ({bus.HREADYOUT, bus.HRESP, bus.PENABLE, bus.PWRITE} !== 4'b1000) begin errors++; $display("FAIL reset_ctrl got %b want 1000", {bus.HREADYOUT, bus.HRESP, bus.PENABLE, bus.PWRITE}); end
    checks++; if (bus.PSEL !== '0 || bus.PSTRB !== '0) begin errors++; $display("FAIL reset_sel_strb got %b/%b want 0/0", bus.PSEL, bus.PSTRB); end
    checks++; if ({bus.HRDATA, bus.PWDATA, bus.PADDR} !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", bus.HRDATA, bus.PWDATA, bus.PADDR); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    int lat; bit resp, rprev; logic [31:0] rd; int n0;
    cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = 32'hDEADBEEF; n0 = apb_cnt;
    do_xfer(32'h0001_0040, 1'b0, 3'd2, 32'h0, lat, resp, rprev, rd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL t1_latency got %0d want 3", lat); end
    checks++; if (resp !== 1'b0) begin errors++; $display("FAIL t1_hresp got %b want 0", resp); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_hrdata got %h want deadbeef", rd); end
    checks++; if (apb_cnt - n0 !== 1) begin errors++; $display("FAIL t1_apb_count got %0d want 1", apb_cnt - n0); end
    checks++; if ({l_sel, l_addr, l_write, l_strb} !== {3'b010, 16'h0040, 1'b0, 4'h0}) begin errors++; $display("FAIL t1_apb got sel %b addr %h wr %b strb %b want 010 0040 0 0000", l_sel, l_addr, l_write, l_strb); end
    model_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_write_byte();
    int lat; bit resp, rprev; logic [31:0] rd;
    @(posedge clk); #1;
    do_xfer(32'h0002_0013, 1'b1, 3'd0, 32'hAABBCCDD, lat, resp, rprev, rd);
    checks++; if (lat !== 4 || resp !== 1'b0) begin errors++; $display("FAIL t2_latency_resp got %0d/%b want 4/0", lat, resp); end
    checks++; if ({l_sel, l_strb, l_write} !== {3'b100, 4'b1000, 1'b1}) begin errors++; $display("FAIL t2_sel_strb got %b %b %b want 100 1000 1", l_sel, l_strb, l_write); end
    checks++; if (l_wdata !== 32'hAABBCCDD || l_addr !== 16'h0013) begin errors++; $display("FAIL t2_wdata_addr got %h/%h want aabbccdd/0013", l_wdata, l_addr); end
    checks++; if (rd !== model_rdata) begin errors++; $display("FAIL t2_hrdata_hold got %h want %h", rd, model_rdata); end
  endtask

  task automatic test_wait_states();
    int lat; bit resp, rprev; logic [31:0] rd;
    cfg_waits = 5; cfg_rdata = $urandom; stab_err = 0;
    @(posedge clk); #1;
    do_xfer(32'h0000_0008, 1'b0, 3'd2, 32'h0, lat, resp, rprev, rd);
    checks++; if (lat !== 8) begin errors++; $display("FAIL t3_latency got %0d want 8", lat); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL t3_stable got %0d violations want 0", stab_err); end
    checks++; if (rd !== cfg_rdata) begin errors++; $display("FAIL t3_hrdata got %h want %h", rd, cfg_rdata); end
    model_rdata = cfg_rdata; cfg_waits = 0;
  endtask

  task automatic test_slverr();
    int lat; bit resp, rprev; logic [31:0] rd; int n0;
    cfg_waits = 1; cfg_err = 1'b1; n0 = apb_cnt;
    @(posedge clk); #1;
    do_xfer(32'h0001_0100, 1'b1, 3'd2, 32'h1234_5678, lat, resp, rprev, rd);
    checks++; if (lat !== 6) begin errors++; $display("FAIL t4_latency got %0d want 6", lat); end
    checks++; if ({rprev, resp} !== 2'b11) begin errors++; $display("FAIL t4_error_pair got %b want 11", {rprev, resp}); end
    checks++; if (apb_cnt - n0 !== 1) begin errors++; $display("FAIL t4_apb_count got %0d want 1", apb_cnt - n0); end
    cfg_waits = 0; cfg_err = 1'b0;
  endtask

  task automatic test_decode_back_to_back();
    int lat; bit resp, rprev; logic [31:0] rd; int n0;
    n0 = apb_cnt;
    @(posedge clk); #1;
    do_xfer(32'h0003_0000, 1'b0, 3'd2, 32'h0, lat, resp, rprev, rd);
    checks++; if (lat !== 2 || {rprev, resp} !== 2'b11) begin errors++; $display("FAIL t5_decode got lat %0d resp %b want 2 11", lat, {rprev, resp}); end
    checks++; if (apb_cnt - n0 !== 0) begin errors++; $display("FAIL t5_no_psel got %0d accesses want 0", apb_cnt - n0); end
    cfg_rdata = $urandom;
    do_xfer(32'h0001_0004, 1'b0, 3'd2, 32'h0, lat, resp, rprev, rd);
    checks++; if (lat !== 3 || resp !== 1'b0 || rd !== cfg_rdata) begin errors++; $display("FAIL t5_b2b got lat %0d resp %b data %h want 3 0 %h", lat, resp, rd, cfg_rdata); end
    model_rdata = cfg_rdata;
    do_xfer(32'h0000_0001, 1'b1, 3'd1, 32'h0, lat, resp, rprev, rd);
    checks++; if (lat !== 2 || resp !== 1'b1) begin errors++; $display("FAIL t5_unaligned got lat %0d resp %b want 2 1", lat, resp); end
  endtask

  task automatic test_idle_busy();
    int n0;
    n0 = apb_cnt;
    @(posedge clk); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b00;
    @(posedge clk); #1 bus.HTRANS = 2'b01;
    @(negedge clk);
    checks++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) begin errors++; $display("FAIL idle_okay got %b want 10", {bus.HREADYOUT, bus.HRESP}); end
    @(posedge clk); #1 bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    @(negedge clk);
    checks++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b10 || apb_cnt !== n0) begin errors++; $display("FAIL busy_okay got %b/%0d want 10/%0d", {bus.HREADYOUT, bus.HRESP}, apb_cnt, n0); end
  endtask

  task automatic test_random();
    int lat, elat, napb, n0, waits; bit resp, rprev, err, w; logic [31:0] rd, a, wd; logic [2:0] sz;
    logic [NS-1:0] esel; logic [3:0] estrb;
    stab_err = 0;
    for (int k = 0; k < 60; k++) begin
      a = $urandom; a[17:16] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      w = 1'($urandom_range(0, 1)); wd = $urandom; waits = $urandom_range(0, 3);
      cfg_waits = waits; cfg_err = ($urandom_range(0, 5) == 0); cfg_rdata = $urandom;
      model(a, w, sz, waits, cfg_err, err, elat, napb, esel, estrb);
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      n0 = apb_cnt;
      do_xfer(a, w, sz, wd, lat, resp, rprev, rd);
      checks++; if (lat !== elat || resp !== err || rprev !== err) begin errors++; $display("FAIL rnd%0d_timing a=%h got lat %0d resp %b%b want %0d %b%b", k, a, lat, rprev, resp, elat, err, err); end
      if (!err && !w) model_rdata = cfg_rdata;
      checks++; if (rd !== model_rdata) begin errors++; $display("FAIL rnd%0d_hrdata got %h want %h", k, rd, model_rdata); end
      checks++; if (apb_cnt - n0 !== napb) begin errors++; $display("FAIL rnd%0d_apb_count got %0d want %0d", k, apb_cnt - n0, napb); end
      if (napb == 1) begin
        checks++; if ({l_sel, l_addr, l_write, l_strb} !== {esel, a[15:0], w, estrb}) begin errors++; $display("FAIL rnd%0d_apb got %b %h %b %b want %b %h %b %b", k, l_sel, l_addr, l_write, l_strb, esel, a[15:0], w, estrb); end
        if (w) begin checks++; if (l_wdata !== wd) begin errors++; $display("FAIL rnd%0d_pwdata got %h want %h", k, l_wdata, wd); end end
      end
    end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL rnd_stable got %0d violations want 0", stab_err); end
    cfg_waits = 0; cfg_err = 1'b0;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int lat; bit resp, rprev; logic [31:0] rd; int n0;
    cfg_waits = 1000; n0 = apb_cnt;
    @(posedge clk); #1;
    do_xfer(32'h0000_0010, 1'b0, 3'd2, 32'h0, lat, resp, rprev, rd);
    checks++; if (lat !== TMO + 3 || {rprev, resp} !== 2'b11) begin errors++; $display("FAIL t6_timeout got lat %0d resp %b want %0d 11", lat, {rprev, resp}, TMO + 3); end
    checks++; if (rd !== model_rdata || apb_cnt !== n0 || bus.PSEL !== '0) begin errors++; $display("FAIL t6_abort got data %h psel %b want %h 000", rd, bus.PSEL, model_rdata); end
    cfg_waits = 0;
  endtask
`endif

  task automatic test_reset_mid_access();
    int lat; bit resp, rprev; logic [31:0] rd;
    cfg_waits = 1000;
    @(posedge clk); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h0002_0020; bus.HWRITE = 1'b0; bus.HSIZE = 3'd2;
    @(posedge clk); #1 bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    repeat (4) @(negedge clk);
    checks++; if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT} !== 5'b10010) begin errors++; $display("FAIL t6_in_access got %b want 10010", {bus.PSEL, bus.PENABLE, bus.HREADYOUT}); end
    rst_n = 1'b0; #1;
    checks++; if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP} !== 6'b000010) begin errors++; $display("FAIL t6_async_reset got %b want 000010", {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP}); end
    checks++; if ({bus.HRDATA, bus.PADDR, bus.PSTRB} !== '0) begin errors++; $display("FAIL t6_reset_data got %h %h %b want 0", bus.HRDATA, bus.PADDR, bus.PSTRB); end
    model_rdata = 32'h0; cfg_waits = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cfg_rdata = $urandom;
    do_xfer(32'h0000_0004, 1'b0, 3'd2, 32'h0, lat, resp, rprev, rd);
    checks++; if (lat !== 3 || resp !== 1'b0 || rd !== cfg_rdata) begin errors++; $display("FAIL t6_recover got lat %0d resp %b data %h want 3 0 %h", lat, resp, rd, cfg_rdata); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_byte();
    test_wait_states();
    test_slverr();
    test_decode_back_to_back();
    test_idle_busy();
    test_random();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
